alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one instance of the existing combinational `alu` module between two requesters (port 0, port 1), e.g. the execute stage and an address/branch-compare helper. Arbitration is round-robin with a valid/ready handshake on each request port. Each port has its own registered result slot with its own valid/ready handshake. Optionally masks shift amounts to RV32I semantics before the ALU.

Parameters:
MASK_SHAMT, 1, when 1, b[31:5] is forced to 0 for op 8'h3/8'h7/8'h8 (sll/srl/sra); when 0, b is passed unmodified.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle when high with req0_valid
req0_a  input  32  port 0 operand a
req0_b  input  32  port 0 operand b
req0_op  input  8  port 0 ALU op code (alu encoding 8'h1..8'ha, others yield 0)
rsp0_valid  output  1  port 0 result valid
rsp0_ready  input  1  port 0 consumer accepts result
rsp0_y  output  32  port 0 result
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for port 1
rsp1_valid, rsp1_ready, rsp1_y  same as port 0, for port 1
last_grant  output  1  index of the most recently granted port
op_cnt  output  CNT_W  count of accepted requests, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low at a clk edge): rsp0_valid=rsp1_valid=0, rsp0_y=rsp1_y=0, last_grant=1 so port 0 wins the first tie, op_cnt=0. Reset mid-operation discards any held result; a request presented during reset is not accepted.
- During reset, req0_ready=req1_ready=0.
- Slot free: free_i = !rspi_valid || rspi_ready (same-cycle drain allowed). eligible_i = reqi_valid && free_i.
- Grant is combinational and at most one port per cycle:
  - only one port eligible -> grant it;
  - both eligible -> grant !last_grant;
  - none eligible -> no grant.
- reqi_ready = (grant==i), and it is low in every other case. reqi_ready may depend on reqi_valid; requesters must not wait for ready before asserting valid.
- On an accepted request (valid && ready) at edge N:
  - the ALU output computed from the granted port's a/b/op (after the shift mask) is registered into rspi_y;
  - rspi_valid=1 from cycle N+1, giving 1-cycle latency;
  - last_grant<=i;
  - op_cnt<=op_cnt+1, wrapping all-ones to 0.
- ALU operand mux selects the granted port. With no grant, the mux selects port 0 and the result is not captured.
- Results:
  - rspi_valid stays high, and rspi_y stays stable, until rspi_ready is high.
  - On rspi_ready with no new accept to port i, rspi_valid<=0; rspi_y holds its last value.
  - On rspi_ready with a simultaneous accept to port i, rspi_valid stays 1 and rspi_y takes the new result (back-to-back, one op per cycle per port).
- Backpressure: while rspi_valid && !rspi_ready, port i is ineligible. The other port may use the ALU every cycle.
- Starvation bound: with both ports eligible every cycle, grants strictly alternate 0,1,0,1.
- Ops and arithmetic are exactly those of `alu`. Invalid op codes (0, 8'hb..8'hff) are accepted normally and produce y=0.
- Shift mask (MASK_SHAMT=1): sll with b=32'h21 behaves as a shift of 1. With MASK_SHAMT=0 the same request yields 0.

Test Plan:
- Reset then single request: req0 {a=5, b=7, op=8'h1}, rsp0_ready=1 -> req0_ready=1 at edge N; rsp0_valid=1 and rsp0_y=12 at N+1; op_cnt=1; last_grant=0.
- Tie with round-robin: both ports valid continuously after reset, port0 op=8'h2 (a=10, b=3), port1 op=8'h6 (a=32'hF0, b=32'hFF), both rsp_ready=1 -> grants 0,1,0,1 in that order; rsp0_y=7; rsp1_y=32'h0F.
- Backpressure: port0 result held with rsp0_ready=0 for 3 cycles while req0 and req1 are both valid -> req0_ready=0 throughout, rsp0_y stable, port1 granted every cycle; on the first rsp0_ready=1 cycle, port0 is re-granted and receives its next result the following cycle.
- Signed ops and shift mask: sra a=32'h80000000 b=32'h24 with MASK_SHAMT=1 -> 32'hF8000000. slt a=32'hFFFFFFFF b=1 -> 1. sltu with the same operands -> 0.
- Invalid op / wrap: op=8'h0 -> y=0 and request accepted. Preload op_cnt to all-ones via 2^CNT_W-1 accepts (or use CNT_W=4, 15 accepts), then one more accept -> op_cnt=0.
- Reset mid-operation: rsp1_valid=1 and req0 valid when rst_n falls -> next cycle rsp0_valid=rsp1_valid=0, rsp0_y=rsp1_y=0, op_cnt=0, last_grant=1, no request accepted during reset.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 32-bit ALU. Op codes 8'h1..8'ha select
//               add/sub/sll/slt/sltu/xor/srl/sra/or/and. Any other op code
//               yields zero. Shift amounts use the full b operand, so a
//               shift of 32 or more gives 0 for sll/srl and sign fill for sra.
// Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [7:0]  op,
    output logic [31:0] y
);

    localparam logic [7:0] c_op_add  = 8'h1;
    localparam logic [7:0] c_op_sub  = 8'h2;
    localparam logic [7:0] c_op_sll  = 8'h3;
    localparam logic [7:0] c_op_slt  = 8'h4;
    localparam logic [7:0] c_op_sltu = 8'h5;
    localparam logic [7:0] c_op_xor  = 8'h6;
    localparam logic [7:0] c_op_srl  = 8'h7;
    localparam logic [7:0] c_op_sra  = 8'h8;
    localparam logic [7:0] c_op_or   = 8'h9;
    localparam logic [7:0] c_op_and  = 8'ha;

    // Evaluate the selected operation; unknown op codes produce zero
    always_comb begin
        y = 32'h0;
        case (op)
            c_op_add:  y = a + b;
            c_op_sub:  y = a - b;
            c_op_sll:  y = a << b;
            c_op_slt:  y = {31'h0, ($signed(a) < $signed(b))};
            c_op_sltu: y = {31'h0, (a < b)};
            c_op_xor:  y = a ^ b;
            c_op_srl:  y = a >> b;
            c_op_sra:  y = $unsigned($signed(a) >>> b);
            c_op_or:   y = a | b;
            c_op_and:  y = a & b;
            default:   y = 32'h0;
        endcase
    end

endmodule

// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares a single alu between two requesters with round-robin
//               arbitration, valid/ready request handshakes and a registered,
//               individually back-pressured result slot per port. Optionally
//               restricts shift amounts to b[4:0].
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int MASK_SHAMT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [7:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_y,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [7:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_y,

    output logic             last_grant,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic        w_elig0;
    logic        w_elig1;
    logic        w_grant0;
    logic        w_grant1;
    logic [31:0] w_a;
    logic [31:0] w_b_raw;
    logic [31:0] w_b;
    logic [7:0]  w_op;
    logic [31:0] w_y;

    // A port is eligible when it requests and its result slot is empty or
    // draining this cycle; nothing is granted while reset is asserted.
    // On a tie the port that did not win last time is granted.
    always_comb begin
        w_elig0  = rst_n && req0_valid && (!rsp0_valid || rsp0_ready);
        w_elig1  = rst_n && req1_valid && (!rsp1_valid || rsp1_ready);
        w_grant0 = w_elig0 && (!w_elig1 || last_grant);
        w_grant1 = w_elig1 && (!w_elig0 || !last_grant);
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Operand mux follows the grant; port 0 is selected when idle
    always_comb begin
        w_a     = req0_a;
        w_b_raw = req0_b;
        w_op    = req0_op;
        if (w_grant1) begin
            w_a     = req1_a;
            w_b_raw = req1_b;
            w_op    = req1_op;
        end
    end

    generate
        if (MASK_SHAMT != 0) begin : g_mask_shamt
            logic w_is_shift;
            assign w_is_shift = (w_op == 8'h3) || (w_op == 8'h7) || (w_op == 8'h8);
            assign w_b        = w_is_shift ? {27'h0, w_b_raw[4:0]} : w_b_raw;
        end else begin : g_pass_shamt
            assign w_b = w_b_raw;
        end
    endgenerate

    alu u_alu (
        .a  (w_a),
        .b  (w_b),
        .op (w_op),
        .y  (w_y)
    );

    // Port 0 result slot: capture on accept, release when consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_y     <= 32'h0;
        end else if (w_grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_y     <= w_y;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    // Port 1 result slot: capture on accept, release when consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_y     <= 32'h0;
        end else if (w_grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_y     <= w_y;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

    // Remember the winner and count accepted requests; reset favours port 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_cnt     <= '0;
        end else if (w_grant0 || w_grant1) begin
            last_grant <= w_grant1;
            op_cnt     <= op_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int MASK_SHAMT = 1;
    localparam int CNT_W      = 4;
    localparam int CNT_MOD    = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [7:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [31:0]      rsp0_y, rsp1_y;
    logic             last_grant;
    logic [CNT_W-1:0] op_cnt;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .MASK_SHAMT (MASK_SHAMT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_y     (rsp0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_y     (rsp1_y),
        .last_grant (last_grant),
        .op_cnt     (op_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference ALU written straight from the op-code table
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
        logic [31:0] sh;
        sh = b;
        if (MASK_SHAMT != 0 && (op == 8'h3 || op == 8'h7 || op == 8'h8)) sh = {27'd0, b[4:0]};
        case (op)
            8'h1: return a + b;
            8'h2: return a - b;
            8'h3: return (sh >= 32) ? 32'd0 : (a << sh[4:0]);
            8'h4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8'h5: return (a < b) ? 32'd1 : 32'd0;
            8'h6: return a ^ b;
            8'h7: return (sh >= 32) ? 32'd0 : (a >> sh[4:0]);
            8'h8: begin
                if (sh >= 32) return a[31] ? 32'hFFFF_FFFF : 32'd0;
                return $unsigned($signed(a) >>> sh[4:0]);
            end
            8'h9: return a | b;
            8'ha: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural model state: expected registered outputs
    logic        m_ok = 1'b0;
    logic [1:0]  m_v;
    logic [31:0] m_y [2];
    logic        m_last;
    int          m_cnt;

    // Compare process: inputs are stable at the falling edge
    always @(negedge clk) begin : p_check
        logic [1:0]  vld, rr, elig;
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        logic [7:0]  rop [2];
        int          g;
        vld = {req1_valid, req0_valid};
        rr  = {rsp1_ready, rsp0_ready};
        ra[0] = req0_a;  rb[0] = req0_b;  rop[0] = req0_op;
        ra[1] = req1_a;  rb[1] = req1_b;  rop[1] = req1_op;
        if (m_ok) begin
            check1("rsp0_valid", rsp0_valid, m_v[0]);
            check1("rsp1_valid", rsp1_valid, m_v[1]);
            check("rsp0_y", rsp0_y, m_y[0]);
            check("rsp1_y", rsp1_y, m_y[1]);
            check1("last_grant", last_grant, m_last);
            check("op_cnt", 32'(op_cnt), 32'(m_cnt));
        end
        g    = -1;
        elig = 2'b00;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) elig[i] = vld[i] && (!m_v[i] || rr[i]);
            if (elig == 2'b11)  g = m_last ? 0 : 1;
            else if (elig[0])   g = 0;
            else if (elig[1])   g = 1;
        end
        if (m_ok) begin
            check1("req0_ready", req0_ready, g == 0);
            check1("req1_ready", req1_ready, g == 1);
        end
        if (rst_n !== 1'b1) begin
            m_v    = 2'b00;
            m_y[0] = 32'd0;
            m_y[1] = 32'd0;
            m_last = 1'b1;
            m_cnt  = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (g == i) begin
                    m_v[i] = 1'b1;
                    m_y[i] = alu_ref(ra[i], rb[i], rop[i]);
                end else if (rr[i]) begin
                    m_v[i] = 1'b0;
                end
            end
            if (g >= 0) begin
                m_last = (g == 1);
                m_cnt  = (m_cnt + 1) % CNT_MOD;
            end
        end
        m_ok = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [7:0] op);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    // One isolated request on port p with a literal expected result
    task automatic single(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] op, input logic [31:0] exp, input string name);
        idle_inputs();
        set_req(p, 1'b1, a, b, op);
        #1;
        check1({name, "_ready"}, (p == 0) ? req0_ready : req1_ready, 1'b1);
        tick();
        check(name, (p == 0) ? rsp0_y : rsp1_y, exp);
        set_req(p, 1'b0, a, b, op);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0;
        idle_inputs();
        set_req(0, 1'b0, 32'd0, 32'd0, 8'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 8'd0);
        do_reset(3);

        // Single request after reset
        set_req(0, 1'b1, 32'd5, 32'd7, 8'h1);
        #1;
        check1("first_ready", req0_ready, 1'b1);
        tick();
        check1("first_valid", rsp0_valid, 1'b1);
        check("first_y", rsp0_y, 32'd12);
        check("first_cnt", 32'(op_cnt), 32'd1);
        check1("first_last", last_grant, 1'b0);
        idle_inputs();
        tick();

        // Tie: grants must alternate starting with port 0
        do_reset(1);
        set_req(0, 1'b1, 32'd10, 32'd3, 8'h2);
        set_req(1, 1'b1, 32'hF0, 32'hFF, 8'h6);
        for (int k = 0; k < 4; k++) begin
            #1;
            check1("rr_ready0", req0_ready, (k % 2) == 0);
            check1("rr_ready1", req1_ready, (k % 2) == 1);
            tick();
        end
        check("rr_y0", rsp0_y, 32'd7);
        check("rr_y1", rsp1_y, 32'h0F);

        // Backpressure on port 0 while both keep requesting
        rsp0_ready = 1'b0;
        tick();
        check1("bp_valid", rsp0_valid, 1'b1);
        held = rsp0_y;
        for (int k = 0; k < 3; k++) begin
            #1;
            check1("bp_ready0", req0_ready, 1'b0);
            check1("bp_ready1", req1_ready, 1'b1);
            tick();
            check("bp_hold", rsp0_y, held);
        end
        rsp0_ready = 1'b1;
        set_req(0, 1'b1, 32'd100, 32'd1, 8'h1);
        #1;
        check1("bp_regrant", req0_ready, 1'b1);
        tick();
        check("bp_next_y", rsp0_y, 32'd101);
        idle_inputs();
        tick();

        // Signed ops, shift masking and invalid op codes
        single(1, 32'h8000_0000, 32'h24, 8'h8, 32'hF800_0000, "sra_mask");
        single(1, 32'hFFFF_FFFF, 32'd1, 8'h4, 32'd1, "slt");
        single(1, 32'hFFFF_FFFF, 32'd1, 8'h5, 32'd0, "sltu");
        single(0, 32'd1, 32'h21, 8'h3, 32'd2, "sll_mask");
        single(0, 32'd5, 32'd5, 8'h0, 32'd0, "op_zero");
        single(1, 32'd5, 32'd5, 8'hc, 32'd0, "op_bad");
        idle_inputs();
        tick();

        // Counter wrap
        do_reset(1);
        set_req(0, 1'b1, 32'd1, 32'd1, 8'h1);
        repeat (CNT_MOD - 1) tick();
        check("cnt_full", 32'(op_cnt), CNT_MOD - 1);
        tick();
        check("cnt_wrap", 32'(op_cnt), 32'd0);
        idle_inputs();
        tick();

        // Randomized traffic checked by the model every cycle
        repeat (400) begin
            set_req(0, $urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                    8'($urandom_range(0, 12)));
            set_req(1, $urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                    8'($urandom_range(0, 12)));
            rsp0_ready = $urandom_range(0, 2) != 0;
            rsp1_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        idle_inputs();
        tick();

        // Reset while a result is held and a request is pending
        rsp1_ready = 1'b0;
        set_req(1, 1'b1, 32'd3, 32'd4, 8'h1);
        tick();
        check1("mid_rsp1_valid", rsp1_valid, 1'b1);
        rst_n = 1'b0;
        set_req(0, 1'b1, 32'd9, 32'd9, 8'h1);
        #1;
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_ready1", req1_ready, 1'b0);
        tick();
        check1("rst_v0", rsp0_valid, 1'b0);
        check1("rst_v1", rsp1_valid, 1'b0);
        check("rst_y0", rsp0_y, 32'd0);
        check("rst_y1", rsp1_y, 32'd0);
        check("rst_cnt", 32'(op_cnt), 32'd0);
        check1("rst_last", last_grant, 1'b1);
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
